// File: rtl/spy_arb_pkg.sv
// Shared types and helpers for the spy-buffer read arbiter: FSM encoding,
// stats counter width and a constant clog2 used to size source indices.
package spy_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ARB  = 2'd2
  } state_t;

  localparam int STAT_W = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/spy_read_arbiter_if.sv
// FIFO read-port bundle plus merged output stream of the spy read arbiter.
// master = arbiter side, slave = FIFOs/downstream side.
interface spy_read_arbiter_if
  import spy_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DSIZE   = 8
);
  localparam int SRC_W = clog2(NUM_SRC);

  logic [NUM_SRC-1:0][DSIZE-1:0] src_rdata;
  logic [NUM_SRC-1:0]            src_rempty;
  logic [NUM_SRC-1:0]            src_en;
  logic [NUM_SRC-1:0]            src_rinc;
  logic [DSIZE-1:0]              out_data;
  logic [SRC_W-1:0]              out_src;
  logic                          out_valid;
  logic                          out_ready;
  logic                          busy;

  modport master (
    input  src_rdata, src_rempty, src_en, out_ready,
    output src_rinc, out_data, out_src, out_valid, busy
  );

  modport slave (
    output src_rdata, src_rempty, src_en, out_ready,
    input  src_rinc, out_data, out_src, out_valid, busy
  );

endinterface

// File: rtl/spy_rr_pick.sv
// Combinational rotating-priority search: first requester strictly after
// 'last', wrapping around so 'last' itself is checked at lowest priority.
module spy_rr_pick
  import spy_arb_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int SRC_W   = clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last,
  output logic [SRC_W-1:0]   gnt_idx,
  output logic               any
);

  logic [SRC_W-1:0] idx;

  // Walk from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    gnt_idx = '0;
    idx     = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx = SRC_W'((int'(last) + i) % NUM_SRC);
      if (req[idx]) gnt_idx = idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/spy_read_arbiter.sv
// Round-robin burst drain of NUM_SRC show-ahead spy FIFOs into one registered
// tagged stream. Optional pop statistics under macro SPY_ARB_STATS_EN.
module spy_read_arbiter
  import spy_arb_pkg::*;
#(
  parameter  int NUM_SRC   = 4,
  parameter  int DSIZE     = 8,
  parameter  int MAX_BURST = 16,
  localparam int SRC_W     = clog2(NUM_SRC)
) (
  input  logic              rclk,
  input  logic              rrst,
`ifdef SPY_ARB_STATS_EN
  input  logic [SRC_W-1:0]  stat_sel,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_cnt,
`endif
  spy_read_arbiter_if.master bus
);

  localparam int BC_W = clog2(MAX_BURST + 1);

  state_t             state, state_nxt;
  logic [SRC_W-1:0]   last_grant, last_grant_nxt, pick_idx;
  logic [BC_W-1:0]    burst_cnt, burst_cnt_nxt;
  logic [NUM_SRC-1:0] req;
  logic               pick_any, load;

  assign req = bus.src_en & ~bus.src_rempty;

  spy_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req     (req),
    .last    (last_grant),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // last_grant doubles as the active grant while in XFER.
  assign load = ~rrst & (state == XFER) & req[last_grant] & (~bus.out_valid | bus.out_ready);

  always_comb begin
    bus.src_rinc = '0;
    if (load) bus.src_rinc[last_grant] = 1'b1;
  end

  assign bus.busy = (state == XFER);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state      <= IDLE;
      last_grant <= SRC_W'(NUM_SRC - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    case (state)
      IDLE, ARB: begin
        if (pick_any) begin
          state_nxt      = XFER;
          last_grant_nxt = pick_idx;
          burst_cnt_nxt  = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      XFER: begin
        // A stalled output keeps the burst open; only pops advance the count.
        if (!req[last_grant]) begin
          state_nxt = ARB;
        end else if (load) begin
          burst_cnt_nxt = burst_cnt + 1'b1;
          if (burst_cnt == BC_W'(MAX_BURST - 1)) state_nxt = ARB;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.src_rdata[last_grant];
      bus.out_src   <= last_grant;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef SPY_ARB_STATS_EN
  logic [STAT_W-1:0] pop_cnt [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_stat
    always_ff @(posedge rclk) begin
      if (rrst || stat_clr)
        pop_cnt[i] <= '0;
      else if (bus.src_rinc[i] && (pop_cnt[i] != '1))
        pop_cnt[i] <= pop_cnt[i] + 1'b1;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) stat_cnt <= '0;
    else      stat_cnt <= pop_cnt[stat_sel];
  end
`endif

endmodule

// File: tb/tb_spy_read_arbiter.sv
// Bench for spy_read_arbiter: queue-based FIFO/stream model, a cycle table for
// the single-source case, directed corner sequences and a randomized run.
module tb_spy_read_arbiter;
  localparam int NS = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic rclk = 1'b0;
  logic rrst = 1'b1;
  always #5 rclk = ~rclk;

  spy_read_arbiter_if #(.NUM_SRC(NS), .DSIZE(DW)) bus ();

`ifdef SPY_ARB_STATS_EN
  logic [1:0]  stat_sel = '0;
  logic        stat_clr = 1'b0;
  logic [31:0] stat_cnt;
`endif

  spy_read_arbiter #(.NUM_SRC(NS), .DSIZE(DW), .MAX_BURST(MB)) dut (
    .rclk     (rclk),
    .rrst     (rrst),
`ifdef SPY_ARB_STATS_EN
    .stat_sel (stat_sel),
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt),
`endif
    .bus      (bus)
  );

  typedef struct {
    int          src;
    logic [DW-1:0] data;
  } word_t;

  typedef struct {
    logic          rdy;
    logic [NS-1:0] rinc;
    logic          vld;
    logic          busy;
    logic [DW-1:0] data;
  } vec_t;

  int            n_chk = 0, n_fail = 0;
  int            n_pop = 0, n_acc = 0;
  logic [DW-1:0] fq [NS][$];
  word_t         pend[$];
  word_t         acc_log[$];
  logic [NS-1:0] rinc_prev = '0;
  int            run_len = 0;
  logic          held_v = 1'b0;
  logic [DW-1:0] held_d;
  logic [1:0]    held_s;
  logic [NS-1:0] s_rinc;
  logic          s_vld, s_busy;
  logic [DW-1:0] s_data;
  logic [1:0]    s_src;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic refresh();
    for (int i = 0; i < NS; i++) begin
      bus.src_rempty[i] = (fq[i].size() == 0);
      bus.src_rdata[i]  = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic push(input int s, input logic [DW-1:0] d);
    fq[s].push_back(d);
    refresh();
  endtask

  // One clock: sample and check at negedge, then apply pops just after posedge.
  task automatic step();
    logic  rst_s;
    word_t w;
    @(negedge rclk);
    rst_s  = rrst;
    s_rinc = bus.src_rinc;
    s_vld  = bus.out_valid;
    s_busy = bus.busy;
    s_data = bus.out_data;
    s_src  = bus.out_src;
    chk("rinc_onehot0", 32'($onehot0(s_rinc)), 1);
    if (rst_s) chk("rinc_in_reset", s_rinc, 0);
    if (held_v) begin
      chk("stall_valid", s_vld, 1);
      chk("stall_data", s_data, held_d);
      chk("stall_src", s_src, held_s);
    end
    held_v = 1'b0;
    if (s_vld && !bus.out_ready) begin
      chk("stall_no_pop", s_rinc, 0);
      held_v = 1'b1; held_d = s_data; held_s = s_src;
    end
    if (s_vld && bus.out_ready) begin
      n_acc++;
      if (pend.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL accept_unexpected: got src %0d data %0h, expected no word", s_src, s_data);
      end else begin
        chk("acc_src", s_src, pend[0].src);
        chk("acc_data", s_data, pend[0].data);
        void'(pend.pop_front());
      end
      w.src = int'(s_src); w.data = s_data;
      acc_log.push_back(w);
    end
    for (int i = 0; i < NS; i++) if (s_rinc[i]) begin
      n_pop++;
      chk("pop_has_req", 32'(bus.src_en[i] & ~bus.src_rempty[i]), 1);
      if (fq[i].size() != 0) begin
        w.src = i; w.data = fq[i][0];
        pend.push_back(w);
      end
    end
    // Pops without a gap must come from one grant, so one source and <= MB long.
    if (s_rinc != 0) begin
      if (rinc_prev != 0) begin
        chk("switch_needs_bubble", s_rinc, rinc_prev);
        run_len++;
      end else run_len = 1;
      chk("burst_len_le_max", 32'(run_len <= MB), 1);
    end
    rinc_prev = s_rinc;
    @(posedge rclk);
    #1;
    for (int i = 0; i < NS; i++) if (s_rinc[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    if (rst_s) begin
      pend.delete();
      held_v = 1'b0;
      rinc_prev = '0;
    end
    refresh();
  endtask

  task automatic fresh_start();
    for (int i = 0; i < NS; i++) fq[i].delete();
    bus.src_en = '1;
    bus.out_ready = 1'b1;
    refresh();
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    acc_log.delete();
  endtask

  task automatic wait_pops(input int s, input int n, input string name);
    int got;
    got = 0;
    for (int c = 0; c < 40 && got < n; c++) begin
      step();
      if (s_rinc[s]) got++;
    end
    if (got < n) begin
      n_chk++; n_fail++;
      $display("FAIL %s: got %0d pops from src %0d, expected %0d", name, got, s, n);
    end
  endtask

  vec_t vt[15];

  initial begin
    int first, acc0, pop0, push0;
    logic [DW-1:0] d;

    // Single source, 10 words in FIFO 2, MAX_BURST=4: bursts 4,4,2 with bubbles.
    vt[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b1, 4'b0100, 1'b0, 1'b1, 8'h00};
    vt[2]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 8'h20};
    vt[3]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 8'h21};
    vt[4]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 8'h22};
    vt[5]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 8'h23};
    vt[6]  = '{1'b1, 4'b0100, 1'b0, 1'b1, 8'h00};
    vt[7]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 8'h24};
    vt[8]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 8'h25};
    vt[9]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 8'h26};
    vt[10] = '{1'b1, 4'b0000, 1'b1, 1'b0, 8'h27};
    vt[11] = '{1'b1, 4'b0100, 1'b0, 1'b1, 8'h00};
    vt[12] = '{1'b1, 4'b0100, 1'b1, 1'b1, 8'h28};
    vt[13] = '{1'b1, 4'b0000, 1'b1, 1'b1, 8'h29};
    vt[14] = '{1'b1, 4'b0000, 1'b0, 1'b0, 8'h00};

    // Reset values
    fresh_start();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_src", bus.out_src, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rinc", bus.src_rinc, 0);

    for (int n = 0; n < 10; n++) push(2, DW'(8'h20 + n));
    for (int k = 0; k < 15; k++) begin
      bus.out_ready = vt[k].rdy;
      step();
      chk($sformatf("t1_rinc[%0d]", k), s_rinc, vt[k].rinc);
      chk($sformatf("t1_valid[%0d]", k), s_vld, vt[k].vld);
      chk($sformatf("t1_busy[%0d]", k), s_busy, vt[k].busy);
      if (vt[k].vld) begin
        chk($sformatf("t1_data[%0d]", k), s_data, vt[k].data);
        chk($sformatf("t1_src[%0d]", k), s_src, 2);
      end
    end

    // Four full FIFOs: grant order 0,1,2,3,0,1,2,3 with 4 words each.
    fresh_start();
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < 8; n++) push(s, DW'(s * 16 + n));
    for (int c = 0; c < 200 && acc_log.size() < 32; c++) step();
    chk("t2_count", acc_log.size(), 32);
    for (int k = 0; k < 32 && k < acc_log.size(); k++) begin
      chk($sformatf("t2_src[%0d]", k), acc_log[k].src, (k / 4) % 4);
      chk($sformatf("t2_data[%0d]", k), acc_log[k].data, ((k / 4) % 4) * 16 + (k / 16) * 4 + k % 4);
    end

    // Backpressure pattern 1,0,0,1 during bursts.
    fresh_start();
    pop0 = n_pop; acc0 = n_acc;
    for (int n = 0; n < 6; n++) push(0, DW'(8'h50 + n));
    for (int c = 0; c < 60; c++) begin
      bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
      step();
    end
    chk("t3_pops", n_pop - pop0, 6);
    chk("t3_accepted", n_acc - acc0, n_pop - pop0);
    chk("t3_fifo_empty", fq[0].size(), 0);
    for (int k = 0; k < 6 && k < acc_log.size(); k++)
      chk($sformatf("t3_data[%0d]", k), acc_log[k].data, 8'h50 + k);

    // Disable source 1 mid-burst: grant moves on to source 2.
    fresh_start();
    for (int n = 0; n < 8; n++) push(1, DW'(8'h10 + n));
    for (int n = 0; n < 4; n++) push(2, DW'(8'h30 + n));
    wait_pops(1, 2, "t4_start");
    bus.src_en[1] = 1'b0;
    first = -1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("t4_no_rinc1", s_rinc[1], 0);
      if (first < 0 && s_rinc != 0) first = oh_idx(s_rinc);
    end
    chk("t4_next_src", first, 2);

    // Reset pulse mid-burst with an unaccepted word in the output register.
    fresh_start();
    for (int n = 0; n < 8; n++) push(2, DW'(8'h40 + n));
    wait_pops(2, 2, "t5_start");
    for (int n = 0; n < 4; n++) push(0, DW'(8'h60 + n));
    bus.out_ready = 1'b0;
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("t5_valid_after_rst", s_vld, 0);
    chk("t5_rinc_after_rst", s_rinc, 0);
    chk("t5_busy_after_rst", s_busy, 0);
    first = -1;
    for (int c = 0; c < 10 && first < 0; c++) begin
      step();
      if (s_rinc != 0) first = oh_idx(s_rinc);
    end
    chk("t5_first_grant", first, 0);

`ifdef SPY_ARB_STATS_EN
    fresh_start();
    for (int n = 0; n < 5; n++) push(3, DW'(n));
    for (int c = 0; c < 20; c++) step();
    stat_sel = 2'd3;
    step(); step();
    chk("stat_cnt_5", stat_cnt, 5);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    step(); step();
    chk("stat_cnt_clr", stat_cnt, 0);
`endif

    // Randomized traffic, enables and backpressure, then a full drain.
    fresh_start();
    acc0 = n_acc; push0 = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        first = $urandom_range(0, NS - 1);
        if (fq[first].size() < 16) begin
          d = DW'($urandom);
          push(first, d);
          push0++;
        end
      end
      if ($urandom_range(0, 19) == 0) bus.src_en[$urandom_range(0, NS - 1)] ^= 1'b1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.src_en = '1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size() == 0 &&
          pend.size() == 0 && !s_vld) break;
      step();
    end
    chk("rand_accepted", n_acc - acc0, push0);
    chk("rand_fifos_empty", fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size(), 0);
    chk("rand_pending_empty", pend.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
